// File: rtl/vga_timing_analyzer_if.sv
// Bundle between a VGA source and the timing analyzer: the video stream
// travels one way and the per-frame measurement set comes back.
interface vga_timing_analyzer_if;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [4:0]  VGA_R;
  logic [5:0]  VGA_G;
  logic [4:0]  VGA_B;
  logic [15:0] H_Total;
  logic [15:0] H_Sync_Len;
  logic [15:0] V_Total;
  logic [15:0] V_Sync_Len;
  logic [15:0] Act_X_First;
  logic [15:0] Act_X_Last;
  logic [15:0] Act_Y_First;
  logic [15:0] Act_Y_Last;
  logic        Act_Found;
  logic        Meas_Valid;
  logic        Locked;
  logic        Timeout;

  modport master (
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    input  H_Total, H_Sync_Len, V_Total, V_Sync_Len,
    input  Act_X_First, Act_X_Last, Act_Y_First, Act_Y_Last,
    input  Act_Found, Meas_Valid, Locked, Timeout
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B,
    output H_Total, H_Sync_Len, V_Total, V_Sync_Len,
    output Act_X_First, Act_X_Last, Act_Y_First, Act_Y_Last,
    output Act_Found, Meas_Valid, Locked, Timeout
  );
endinterface

// File: rtl/vga_timing_analyzer.sv
// Receive-side VGA timing analyzer: measures line/frame timing, sync widths
// and the non-black bounding box, publishes once per frame and reports lock
// once consecutive frames agree. Falls back to searching when HS disappears.
module vga_timing_analyzer #(
  parameter int LOCK_FRAMES    = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  pixel_clk,
  input logic                  pixel_rstn,
  vga_timing_analyzer_if.slave vif
);

  localparam logic [15:0] LOCK_LIM    = 16'(LOCK_FRAMES);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // input register and previous-sample copies
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [15:0] rgb_q;
  // detection stage: edges and levels of one pixel sample, aligned together
  logic        hs_fall, hs_rise, vs_fall, vs_lvl, pix_on;

  // counters
  logic [15:0] h_cnt, v_cnt, idle_cnt;
  logic [15:0] line_period, hs_width, vs_lines;
  // active box trackers
  logic        box_found;
  logic [15:0] x_min, x_max, y_min, y_max;

  // published results and control
  state_t      state;
  logic [15:0] lock_cnt;
  logic [15:0] h_total_r, h_sync_r, v_total_r, v_sync_r;
  logic [15:0] x_first_r, x_last_r, y_first_r, y_last_r;
  logic        found_r, valid_r, locked_r, timeout_r;

  // column/line of the pixel in the detection stage, and derived values
  logic [15:0] h_cur, v_cur, idle_next, v_total_new, lock_next;
  logic        timeout_hit, timing_match;

  assign h_cur       = hs_fall ? 16'd0 : sat_inc(h_cnt);
  assign v_cur       = hs_fall ? (vs_fall ? 16'd0 : sat_inc(v_cnt)) : v_cnt;
  assign idle_next   = hs_fall ? 16'd0 : sat_inc(idle_cnt);
  assign timeout_hit = (idle_next == TIMEOUT_LIM) && (idle_cnt != TIMEOUT_LIM);
  assign v_total_new = sat_inc(v_cnt);
  assign timing_match = (line_period == h_total_r) && (hs_width == h_sync_r) &&
                        (v_total_new == v_total_r) && (vs_lines == v_sync_r);
  assign lock_next   = timing_match ? ((lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 16'd1)
                                    : 16'd1;

  // Register the raw stream, then register edge flags from the registered copies.
  always_ff @(posedge pixel_clk or negedge pixel_rstn) begin
    if (!pixel_rstn) begin
      hs_q    <= 1'b0;
      hs_d    <= 1'b0;
      vs_q    <= 1'b0;
      vs_d    <= 1'b0;
      rgb_q   <= '0;
      hs_fall <= 1'b0;
      hs_rise <= 1'b0;
      vs_fall <= 1'b0;
      vs_lvl  <= 1'b0;
      pix_on  <= 1'b0;
    end else begin
      hs_q    <= vif.VGA_HS;
      vs_q    <= vif.VGA_VS;
      rgb_q   <= {vif.VGA_R, vif.VGA_G, vif.VGA_B};
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      hs_fall <= hs_d & ~hs_q;
      hs_rise <= ~hs_d & hs_q;
      vs_fall <= vs_d & ~vs_q;
      vs_lvl  <= vs_q;
      pix_on  <= |rgb_q;
    end
  end

  // Free-running line/frame counters and the non-black bounding box of the current frame.
  always_ff @(posedge pixel_clk or negedge pixel_rstn) begin
    if (!pixel_rstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      idle_cnt    <= '0;
      line_period <= '0;
      hs_width    <= '0;
      vs_lines    <= '0;
      box_found   <= 1'b0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
    end else begin
      h_cnt    <= h_cur;
      v_cnt    <= v_cur;
      idle_cnt <= idle_next;
      if (hs_fall) line_period <= sat_inc(h_cnt);
      if (hs_rise) hs_width <= h_cur;
      if (vs_fall) vs_lines <= hs_fall ? 16'd1 : 16'd0;
      else if (hs_fall && !vs_lvl) vs_lines <= sat_inc(vs_lines);
      if (vs_fall) begin
        box_found <= pix_on;
        x_min     <= pix_on ? h_cur : 16'd0;
        x_max     <= pix_on ? h_cur : 16'd0;
        y_min     <= pix_on ? v_cur : 16'd0;
        y_max     <= pix_on ? v_cur : 16'd0;
      end else if (pix_on) begin
        box_found <= 1'b1;
        if (!box_found || h_cur < x_min) x_min <= h_cur;
        if (!box_found || h_cur > x_max) x_max <= h_cur;
        if (!box_found || v_cur < y_min) y_min <= v_cur;
        if (!box_found || v_cur > y_max) y_max <= v_cur;
      end
    end
  end

  // Search/measure/lock sequencing with the published measurement registers.
  always_ff @(posedge pixel_clk or negedge pixel_rstn) begin
    if (!pixel_rstn) begin
      state     <= ST_SEARCH;
      lock_cnt  <= '0;
      h_total_r <= '0;
      h_sync_r  <= '0;
      v_total_r <= '0;
      v_sync_r  <= '0;
      x_first_r <= '0;
      x_last_r  <= '0;
      y_first_r <= '0;
      y_last_r  <= '0;
      found_r   <= 1'b0;
      valid_r   <= 1'b0;
      locked_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (hs_fall) timeout_r <= 1'b0;
      if (timeout_hit) begin
        state     <= ST_SEARCH;
        locked_r  <= 1'b0;
        lock_cnt  <= '0;
        timeout_r <= 1'b1;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (vs_fall) state <= ST_MEASURE;
          end
          ST_MEASURE, ST_LOCKED: begin
            if (vs_fall) begin
              valid_r   <= 1'b1;
              h_total_r <= line_period;
              h_sync_r  <= hs_width;
              v_total_r <= v_total_new;
              v_sync_r  <= vs_lines;
              x_first_r <= x_min;
              x_last_r  <= x_max;
              y_first_r <= y_min;
              y_last_r  <= y_max;
              found_r   <= box_found;
              lock_cnt  <= lock_next;
              if (state == ST_LOCKED && !timing_match) begin
                state    <= ST_MEASURE;
                locked_r <= 1'b0;
              end else if (lock_next >= LOCK_LIM) begin
                state    <= ST_LOCKED;
                locked_r <= 1'b1;
              end
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign vif.H_Total     = h_total_r;
  assign vif.H_Sync_Len  = h_sync_r;
  assign vif.V_Total     = v_total_r;
  assign vif.V_Sync_Len  = v_sync_r;
  assign vif.Act_X_First = x_first_r;
  assign vif.Act_X_Last  = x_last_r;
  assign vif.Act_Y_First = y_first_r;
  assign vif.Act_Y_Last  = y_last_r;
  assign vif.Act_Found   = found_r;
  assign vif.Meas_Valid  = valid_r;
  assign vif.Locked      = locked_r;
  assign vif.Timeout     = timeout_r;

endmodule

// File: tb/tb_vga_timing_analyzer.sv
// Scoreboard bench for vga_timing_analyzer: random small video timings are
// streamed in, a frame-level model predicts each publish, and a monitor
// compares every Meas_Valid pulse against the queued prediction.
module tb_vga_timing_analyzer;

  localparam int LOCKN = 3;
  localparam int TMO   = 500;

  logic pixel_clk  = 1'b0;
  logic pixel_rstn = 1'b0;

  vga_timing_analyzer_if vif();

  vga_timing_analyzer #(.LOCK_FRAMES(LOCKN), .TIMEOUT_CYCLES(TMO)) dut (
    .pixel_clk (pixel_clk),
    .pixel_rstn(pixel_rstn),
    .vif       (vif)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  typedef struct {
    int htot; int hsync; int vtot; int vsync;
    int xf; int xl; int yf; int yl; bit empty;
  } frame_t;

  typedef struct {
    int h_total; int h_sync; int v_total; int v_sync;
    int xf; int xl; int yf; int yl; bit found; bit locked; int due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  bit   searching = 1'b1;
  int   run = 0;
  int   prev_ht = 0, prev_hs = 0, prev_vt = 0, prev_vs = 0;
  exp_t done_e;
  bit   cur_found;
  int   cur_xmin, cur_xmax, cur_ymin, cur_ymax;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic [15:0] rgb);
    @(negedge pixel_clk);
    vif.VGA_HS = hs;
    vif.VGA_VS = vs;
    {vif.VGA_R, vif.VGA_G, vif.VGA_B} = rgb;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_H_Total"},     32'(vif.H_Total), 0);
    checkOutput({tag, "_H_Sync_Len"},  32'(vif.H_Sync_Len), 0);
    checkOutput({tag, "_V_Total"},     32'(vif.V_Total), 0);
    checkOutput({tag, "_V_Sync_Len"},  32'(vif.V_Sync_Len), 0);
    checkOutput({tag, "_Act_X_First"}, 32'(vif.Act_X_First), 0);
    checkOutput({tag, "_Act_X_Last"},  32'(vif.Act_X_Last), 0);
    checkOutput({tag, "_Act_Y_First"}, 32'(vif.Act_Y_First), 0);
    checkOutput({tag, "_Act_Y_Last"},  32'(vif.Act_Y_Last), 0);
    checkOutput({tag, "_Act_Found"},   32'(vif.Act_Found), 0);
    checkOutput({tag, "_Meas_Valid"},  32'(vif.Meas_Valid), 0);
    checkOutput({tag, "_Locked"},      32'(vif.Locked), 0);
    checkOutput({tag, "_Timeout"},     32'(vif.Timeout), 0);
  endtask

  task automatic rand_box(inout frame_t f);
    f.empty = ($urandom_range(0, 3) == 0);
    f.xf = $urandom_range(0, f.htot - 1);
    f.xl = $urandom_range(f.xf, f.htot - 1);
    f.yf = $urandom_range(0, f.vtot - 1);
    f.yl = $urandom_range(f.yf, f.vtot - 1);
  endtask

  task automatic rand_timing(output frame_t f);
    f.htot  = $urandom_range(24, 40);
    f.hsync = $urandom_range(2, 8);
    f.vtot  = $urandom_range(8, 16);
    f.vsync = $urandom_range(1, 3);
    rand_box(f);
  endtask

  // called in the cycle the VS fall is driven: the frame just completed is published
  task automatic frame_boundary();
    exp_t e;
    if (searching) begin
      searching = 1'b0;
    end else begin
      e = done_e;
      if (e.h_total == prev_ht && e.h_sync == prev_hs &&
          e.v_total == prev_vt && e.v_sync == prev_vs) run++;
      else run = 1;
      prev_ht = e.h_total; prev_hs = e.h_sync;
      prev_vt = e.v_total; prev_vs = e.v_sync;
      e.locked = (run >= LOCKN);
      e.due = cyc + 3;
      sb.push_back(e);
    end
    cur_found = 1'b0;
    cur_xmin = 0; cur_xmax = 0; cur_ymin = 0; cur_ymax = 0;
  endtask

  task automatic send_frame(input frame_t f, input int max_pix);
    logic [15:0] one;
    logic [15:0] rgb;
    int n;
    one = 16'd1;
    n = 0;
    for (int r = 0; r < f.vtot; r++) begin
      for (int c = 0; c < f.htot; c++) begin
        if (max_pix > 0 && n >= max_pix) return;
        n++;
        rgb = '0;
        if (!f.empty && c >= f.xf && c <= f.xl && r >= f.yf && r <= f.yl &&
            $urandom_range(0, 3) != 0)
          rgb = one << $urandom_range(0, 15);
        applyStimulus(c >= f.hsync, r >= f.vsync, rgb);
        if (r == 0 && c == 0) frame_boundary();
        if (rgb != 0) begin
          if (!cur_found) begin
            cur_found = 1'b1;
            cur_xmin = c; cur_xmax = c; cur_ymin = r; cur_ymax = r;
          end else begin
            if (c < cur_xmin) cur_xmin = c;
            if (c > cur_xmax) cur_xmax = c;
            if (r < cur_ymin) cur_ymin = r;
            if (r > cur_ymax) cur_ymax = r;
          end
        end
      end
    end
    done_e.h_total = f.htot;
    done_e.h_sync  = f.hsync;
    done_e.v_total = f.vtot;
    done_e.v_sync  = f.vsync;
    done_e.found   = cur_found;
    done_e.xf = cur_xmin; done_e.xl = cur_xmax;
    done_e.yf = cur_ymin; done_e.yl = cur_ymax;
  endtask

  task automatic stop_stream();
    applyStimulus(1'b0, 1'b0, 16'd0);
    frame_boundary();
  endtask

  // Monitor: every publish is matched against the oldest prediction; overdue predictions fail.
  exp_t mon_e;
  always @(negedge pixel_clk) begin
    if (vif.Meas_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_publish: got Meas_Valid=1, expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pub_cycle",   32'(cyc), 32'(mon_e.due));
        checkOutput("H_Total",     32'(vif.H_Total), 32'(mon_e.h_total));
        checkOutput("H_Sync_Len",  32'(vif.H_Sync_Len), 32'(mon_e.h_sync));
        checkOutput("V_Total",     32'(vif.V_Total), 32'(mon_e.v_total));
        checkOutput("V_Sync_Len",  32'(vif.V_Sync_Len), 32'(mon_e.v_sync));
        checkOutput("Act_Found",   32'(vif.Act_Found), 32'(mon_e.found));
        checkOutput("Act_X_First", 32'(vif.Act_X_First), 32'(mon_e.xf));
        checkOutput("Act_X_Last",  32'(vif.Act_X_Last), 32'(mon_e.xl));
        checkOutput("Act_Y_First", 32'(vif.Act_Y_First), 32'(mon_e.yf));
        checkOutput("Act_Y_Last",  32'(vif.Act_Y_Last), 32'(mon_e.yl));
        checkOutput("Locked",      32'(vif.Locked), 32'(mon_e.locked));
        checkOutput("pub_Timeout", 32'(vif.Timeout), 0);
      end
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_publish: got no Meas_Valid, expected one at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
  end

  frame_t fa, fb, fr;

  initial begin
    vif.VGA_HS = 1'b1;
    vif.VGA_VS = 1'b1;
    {vif.VGA_R, vif.VGA_G, vif.VGA_B} = 16'd0;
    repeat (3) @(negedge pixel_clk);
    check_all_zero("reset");
    pixel_rstn = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b1, 16'd0);

    $display("[TB] stable stream, lock acquisition");
    rand_timing(fa);
    for (int i = 0; i < 6; i++) begin
      rand_box(fa);
      send_frame(fa, 0);
    end

    $display("[TB] one frame with wider HS, then relock");
    fb = fa;
    fb.hsync = fa.hsync + 1;
    send_frame(fb, 0);
    for (int i = 0; i < 3; i++) begin
      rand_box(fa);
      send_frame(fa, 0);
    end

    $display("[TB] randomized timings including all-black frames");
    fr = fa;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) rand_timing(fr);
      else rand_box(fr);
      if (i == 3 || i == 4) fr.empty = 1'b1;
      send_frame(fr, 0);
    end

    $display("[TB] generator stopped, waiting for timeout");
    stop_stream();
    repeat (480) @(negedge pixel_clk);
    checkOutput("timeout_early", 32'(vif.Timeout), 0);
    repeat (40) @(negedge pixel_clk);
    checkOutput("timeout_set", 32'(vif.Timeout), 1);
    checkOutput("timeout_unlock", 32'(vif.Locked), 0);
    checkOutput("timeout_hold_H_Total", 32'(vif.H_Total), 32'(prev_ht));
    checkOutput("timeout_hold_V_Total", 32'(vif.V_Total), 32'(prev_vt));
    searching = 1'b1;
    run = 0;

    $display("[TB] stream restarted");
    repeat (3) applyStimulus(1'b1, 1'b1, 16'd0);
    rand_box(fa);
    fork
      send_frame(fa, 0);
      begin
        repeat (6) @(negedge pixel_clk);
        checkOutput("timeout_cleared", 32'(vif.Timeout), 0);
      end
    join
    for (int i = 0; i < 3; i++) begin
      rand_box(fa);
      send_frame(fa, 0);
    end

    $display("[TB] reset mid-frame");
    rand_box(fa);
    send_frame(fa, 50);
    @(negedge pixel_clk);
    pixel_rstn = 1'b0;
    vif.VGA_HS = 1'b1;
    vif.VGA_VS = 1'b1;
    #1;
    check_all_zero("midreset");
    searching = 1'b1;
    run = 0;
    prev_ht = 0; prev_hs = 0; prev_vt = 0; prev_vs = 0;
    repeat (3) @(negedge pixel_clk);
    pixel_rstn = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      rand_box(fa);
      send_frame(fa, 0);
    end
    stop_stream();
    repeat (10) @(negedge pixel_clk);

    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
